// File: rtl/fb_writer.sv
// ============================================================================
// Module  : fb_writer
// Purpose : Pixel-copy stream sink. Decodes screen/tile offsets into linear
//           framebuffer addresses and drains them through a FIFO to the RAM.
// Option  : FB_WRITER_TRANSPARENT_KEY_EN drops magenta-key (15'h7C1F) pixels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_writer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int TILE       = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode,
  input  logic [4:0]  tile_col,
  input  logic [3:0]  tile_row,
  input  logic        in_valid,
  input  logic [14:0] in_colour,
  input  logic [16:0] in_offset,
  input  logic        in_finished,
  input  logic        fb_ready,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [14:0] fb_data,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int         c_tw     = $clog2(TILE);
  localparam int         c_aw     = $clog2(FIFO_DEPTH);
  localparam logic [9:0] c_width  = 10'(WIDTH);
  localparam logic [8:0] c_height = 9'(HEIGHT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;

  logic        r_mode;
  logic [4:0]  r_tile_col;
  logic [3:0]  r_tile_row;

  logic        w_idle;
  logic        w_accept;
  logic        w_cfg_mode;
  logic [4:0]  w_cfg_col;
  logic [3:0]  w_cfg_row;
  logic [8:0]  w_x;
  logic [7:0]  w_y;
  logic        w_in_range;
  logic        w_keep;

  logic        r_s1_valid;
  logic [8:0]  r_s1_x;
  logic [7:0]  r_s1_y;
  logic [14:0] r_s1_colour;
  logic [16:0] w_addr;

  logic [31:0]  r_mem [FIFO_DEPTH];
  logic [c_aw:0] r_wr_ptr;
  logic [c_aw:0] r_rd_ptr;
  logic        w_fifo_empty;
  logic        w_fifo_full;
  logic        w_push_ok;
  logic        w_pop;
  logic        w_drop;

  logic        r_out_valid;
  logic        w_out_load;
  logic        w_all_empty;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = in_valid && (w_idle || r_state == S_RUN);

  // The pixel that leaves S_IDLE carries the configuration it must use.
  assign w_cfg_mode = w_idle ? mode     : r_mode;
  assign w_cfg_col  = w_idle ? tile_col : r_tile_col;
  assign w_cfg_row  = w_idle ? tile_row : r_tile_row;

  always_comb begin
    w_x = in_offset[8:0];
    w_y = in_offset[16:9];
    if (w_cfg_mode) begin
      w_x = (9'(w_cfg_col) << c_tw) + 9'(in_offset[c_tw-1:0]);
      w_y = (8'(w_cfg_row) << c_tw) + 8'(in_offset[2*c_tw-1:c_tw]);
    end
  end

  assign w_in_range = ({1'b0, w_x} < c_width) && ({1'b0, w_y} < c_height);

`ifdef FB_WRITER_TRANSPARENT_KEY_EN
  assign w_keep = (in_colour != 15'h7C1F);
`else
  assign w_keep = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode     <= 1'b0;
      r_tile_col <= '0;
      r_tile_row <= '0;
    end else if (w_idle && in_valid) begin
      r_mode     <= mode;
      r_tile_col <= tile_col;
      r_tile_row <= tile_row;
    end
  end

  // Stage 1: decoded coordinates
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_colour <= '0;
    end else begin
      r_s1_valid  <= w_accept && w_in_range && w_keep;
      r_s1_x      <= w_x;
      r_s1_y      <= w_y;
      r_s1_colour <= in_colour;
    end
  end

  // Stage 2: the FIFO entry itself is the registered linear address.
  assign w_addr = ({9'd0, r_s1_y} * 17'(WIDTH)) + {8'd0, r_s1_x};

  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

  assign w_out_load = !r_out_valid || fb_ready;
  assign w_pop      = w_out_load && !w_fifo_empty;
  assign w_push_ok  = r_s1_valid && (!w_fifo_full || w_pop);
  assign w_drop     = r_s1_valid && w_fifo_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= {w_addr, r_s1_colour};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
    end else if (w_out_load) begin
      r_out_valid <= !w_fifo_empty;
      if (w_pop) begin
        {fb_addr, fb_data} <= r_mem[r_rd_ptr[c_aw-1:0]];
      end
    end
  end

  assign fb_we = r_out_valid;

  always_ff @(posedge clk) begin
    if (!reset_n)               overflow <= 1'b0;
    else if (w_drop)            overflow <= 1'b1;
    else if (w_idle && in_valid) overflow <= 1'b0;
  end

  assign w_all_empty = !r_s1_valid && w_fifo_empty && !r_out_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_finished) w_next_state = S_FLUSH;
        else if (in_valid)           w_next_state = S_RUN;
        else if (in_finished)        w_next_state = S_DONE;
      end
      S_RUN:   if (in_finished) w_next_state = S_FLUSH;
      S_FLUSH: if (w_all_empty) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_writer.sv
// ============================================================================
// Module  : tb_fb_writer
// Purpose : Scoreboard bench for fb_writer; expected writes are queued by the
//           stimulus and popped by an independent write monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_writer;

  logic        clk;
  logic        reset_n;
  logic        mode;
  logic [4:0]  tile_col;
  logic [3:0]  tile_row;
  logic        in_valid;
  logic [14:0] in_colour;
  logic [16:0] in_offset;
  logic        in_finished;
  logic        fb_ready;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [14:0] fb_data;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_pass   = 0;
  int n_total  = 0;
  int n_writes = 0;
  logic [31:0] exp_q[$];

  fb_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .tile_col    (tile_col),
    .tile_row    (tile_row),
    .in_valid    (in_valid),
    .in_colour   (in_colour),
    .in_offset   (in_offset),
    .in_finished (in_finished),
    .fb_ready    (fb_ready),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void push_exp(input int addr, input logic [14:0] data);
    exp_q.push_back({17'(addr), data});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every transferred word must match the queue head.
  always @(negedge clk) begin
    if (reset_n && fb_we && fb_ready) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("fb_addr", 32'(fb_addr), 32'(e[31:15]));
        check("fb_data", 32'(fb_data), 32'(e[14:0]));
      end
    end
  end

  task automatic wait_done(input int maxc);
    int dones = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (done) dones++;
      if (dones > 0 && !busy) break;
    end
    check("busy_after_done", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dones++;
    end
    check("done_pulses", 32'(dones), 32'd1);
  endtask

  initial begin
    int errs;
    int dn;
    int w0;
    logic seen;

    reset_n = 1'b0; mode = 1'b0; tile_col = '0; tile_row = '0;
    in_valid = 1'b0; in_colour = '0; in_offset = '0; in_finished = 1'b0;
    fb_ready = 1'b1;
    repeat (3) tick();
    check("rst_fb_we",    32'(fb_we),    32'd0);
    check("rst_fb_addr",  32'(fb_addr),  32'd0);
    check("rst_fb_data",  32'(fb_data),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single screen-mode pixel, latency and completion
    mode = 1'b0; in_valid = 1'b1; in_offset = (17'd10 << 9) | 17'd5; in_colour = 15'h1234;
    push_exp(3205, 15'h1234);
    tick();
    in_valid = 1'b0; in_finished = 1'b1;
    check("busy_run", 32'(busy), 32'd1);
    tick();
    in_finished = 1'b0;
    check("lat_n2_we", 32'(fb_we), 32'd0);
    tick();
    check("lat_n3_we", 32'(fb_we), 32'd1);
    wait_done(20);

    // Tile mode: single pixel then a full tile; later config edits are ignored
    mode = 1'b1; tile_col = 5'd2; tile_row = 4'd1;
    in_valid = 1'b1; in_offset = 17'h35; in_colour = 15'h0ABC;
    push_exp(6117, 15'h0ABC);
    tick();
    mode = 1'b0; tile_col = 5'd5; tile_row = 4'd3;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_offset = 17'(i); in_colour = 15'(i);
      in_finished = (i == 255);
      push_exp((16 + (i >> 4)) * 320 + 32 + (i & 15), 15'(i));
      tick();
    end
    in_valid = 1'b0; in_finished = 1'b0;
    wait_done(50);
    check("tile_no_overflow", 32'(overflow), 32'd0);

    // Stall: 12 pixels into a blocked port, 9 survive
    mode = 1'b0; fb_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_offset = (17'(i + 1) << 9) | 17'(i); in_colour = 15'h100 + 15'(i);
      if (i < 9) push_exp((i + 1) * 320 + i, 15'h100 + 15'(i));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (fb_we !== 1'b1 || fb_addr !== 17'd320 || fb_data !== 15'h100) errs++;
      tick();
    end
    check("stall_outputs_stable", 32'(errs), 32'd0);
    check("stall_overflow", 32'(overflow), 32'd1);
    in_finished = 1'b1;
    tick();
    in_finished = 1'b0;
    fb_ready = 1'b1;
    wait_done(40);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Out-of-range pixels are dropped silently
    in_valid = 1'b1; in_offset = 17'd320; in_colour = 15'h0001;
    tick();
    check("overflow_cleared_on_run", 32'(overflow), 32'd0);
    in_offset = 17'd240 << 9; in_colour = 15'h0002;
    tick();
    in_offset = (17'd239 << 9) | 17'd319; in_colour = 15'h0003; in_finished = 1'b1;
    push_exp(76799, 15'h0003);
    tick();
    in_valid = 1'b0; in_finished = 1'b0;
    wait_done(30);
    check("range_no_overflow", 32'(overflow), 32'd0);

    // Empty copy
    in_finished = 1'b1;
    tick();
    in_finished = 1'b0;
    seen = done;
    if (!seen) begin
      tick();
      seen = done;
    end
    check("empty_copy_done", 32'(seen), 32'd1);
    tick();
    check("empty_copy_idle", 32'(busy), 32'd0);

    // Reset in the middle of a stalled tile copy
    mode = 1'b1; tile_col = 5'd0; tile_row = 4'd0; fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_offset = 17'(i); in_colour = 15'h2000 + 15'(i);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    exp_q.delete();
    tick();
    check("mid_rst_fb_we",    32'(fb_we),    32'd0);
    check("mid_rst_fb_addr",  32'(fb_addr),  32'd0);
    check("mid_rst_fb_data",  32'(fb_data),  32'd0);
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_done",     32'(done),     32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1; fb_ready = 1'b1;
    w0 = n_writes;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dn++;
    end
    check("post_rst_no_writes", 32'(n_writes - w0), 32'd0);
    check("post_rst_no_done", 32'(dn), 32'd0);

    // Transparent colour key
    mode = 1'b0;
    in_valid = 1'b1; in_offset = 17'd1; in_colour = 15'h7C1F;
`ifndef FB_WRITER_TRANSPARENT_KEY_EN
    push_exp(1, 15'h7C1F);
`endif
    tick();
    in_offset = 17'd2; in_colour = 15'h0001; in_finished = 1'b1;
    push_exp(2, 15'h0001);
    tick();
    in_valid = 1'b0; in_finished = 1'b0;
    wait_done(30);

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
